// File: rtl/axi_read_dma_engine_if.sv
// Bus bundle for the read-DMA engine: command input, AXI AR/R channels and the forwarded beat stream.
// The master modport is the engine side; the slave modport is the environment side.
interface axi_read_dma_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [SIZE_WIDTH-1:0] cmd_size;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  cmd_addr, cmd_size, cmd_valid, arready, rdata, rlast, rvalid, out_ready,
    output cmd_ready, araddr, arlen, arvalid, rready, out_data, out_valid
  );

  modport slave (
    output cmd_addr, cmd_size, cmd_valid, arready, rdata, rlast, rvalid, out_ready,
    input  cmd_ready, araddr, arlen, arvalid, rready, out_data, out_valid
  );
endinterface

// File: rtl/axi_read_dma_engine.sv
// Read-DMA command engine: splits (address, beat count) commands into INCR bursts that respect
// MAX_BURST_LEN and 4KB boundaries, and forwards returned beats to a valid/ready stream.
module axi_read_dma_engine #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 24,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axi_read_dma_engine_if.master       bus,
  output logic                        busy,
  output logic                        done,
  output logic                        len_error
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int CW         = (SIZE_WIDTH > 13) ? SIZE_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << BEAT_SHIFT) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [SIZE_WIDTH-1:0] remaining_r;
  logic [8:0]            burst_len_r;
  logic [8:0]            beat_cnt_r;
  logic                  done_r;
  logic                  len_error_r;

  logic [8:0]            burst_len_s;
  logic                  cmd_ready_s;
  logic                  arvalid_s;
  logic                  rready_s;
  logic                  out_valid_s;
  logic                  beat_fire_s;
  logic                  last_beat_s;
  logic                  cmd_last_s;

  // Beats in the next burst: limited by what is left, the burst cap and the distance to the 4KB page end.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [SIZE_WIDTH-1:0] rem);
    logic [CW-1:0] lim_4k;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] len_w;
    lim_4k = CW'((13'd4096 - {1'b0, page_off}) >> BEAT_SHIFT);
    rem_w  = CW'(rem);
    max_w  = CW'(MAX_BURST_LEN);
    len_w  = (rem_w < max_w) ? rem_w : max_w;
    len_w  = (lim_4k < len_w) ? lim_4k : len_w;
    return 9'(len_w);
  endfunction

  assign burst_len_s = burst_beats(cur_addr_r[11:0], remaining_r);
  assign beat_fire_s = bus.rvalid & rready_s;
  assign last_beat_s = (beat_cnt_r == (burst_len_r - 9'd1));
  assign cmd_last_s  = (remaining_r == SIZE_WIDTH'(burst_len_r));

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    cmd_ready_s = 1'b0;
    arvalid_s   = 1'b0;
    rready_s    = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid && (bus.cmd_size != {SIZE_WIDTH{1'b0}})) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        arvalid_s = 1'b1;
        if (bus.arready) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        rready_s    = bus.out_ready;
        out_valid_s = bus.rvalid;
        if (bus.rvalid && bus.out_ready && last_beat_s) begin
          state_nxt_s = cmd_last_s ? ST_IDLE : ST_ADDR;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Command datapath: address/remaining bookkeeping, beat counting, done pulse and sticky length error.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {SIZE_WIDTH{1'b0}};
      burst_len_r <= 9'd0;
      beat_cnt_r  <= 9'd0;
      done_r      <= 1'b0;
      len_error_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          beat_cnt_r <= 9'd0;
          if (bus.cmd_valid) begin
            cur_addr_r  <= bus.cmd_addr & ALIGN_MASK;
            remaining_r <= bus.cmd_size;
            done_r      <= (bus.cmd_size == {SIZE_WIDTH{1'b0}});
          end
        end
        ST_ADDR: begin
          beat_cnt_r <= 9'd0;
          if (bus.arready) begin
            burst_len_r <= burst_len_s;
          end
        end
        ST_DATA: begin
          if (beat_fire_s) begin
            // Completion tracks the internal count; rlast only feeds the error flag.
            if (bus.rlast != last_beat_s) begin
              len_error_r <= 1'b1;
            end
            if (last_beat_s) begin
              beat_cnt_r  <= 9'd0;
              cur_addr_r  <= cur_addr_r + (ADDR_WIDTH'(burst_len_r) << BEAT_SHIFT);
              remaining_r <= remaining_r - SIZE_WIDTH'(burst_len_r);
              done_r      <= cmd_last_s;
            end else begin
              beat_cnt_r <= beat_cnt_r + 9'd1;
            end
          end
        end
        default: begin
          beat_cnt_r <= 9'd0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.arvalid   = arvalid_s;
  assign bus.araddr    = arvalid_s ? cur_addr_r : {ADDR_WIDTH{1'b0}};
  assign bus.arlen     = arvalid_s ? 8'(burst_len_s - 9'd1) : 8'd0;
  assign bus.rready    = rready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = (state_r == ST_DATA) ? bus.rdata : {DATA_WIDTH{1'b0}};
  assign busy          = (state_r != ST_IDLE);
  assign done          = done_r;
  assign len_error     = len_error_r;

endmodule

// File: tb/tb_axi_read_dma_engine.sv
// Bench for axi_read_dma_engine: directed and randomized commands against a burst-splitting
// reference model, with a randomized AXI slave and consumer.
module tb_axi_read_dma_engine;

  logic ACLK;
  logic ARESET;
  logic busy;
  logic done;
  logic len_error;

  int   n_vec;
  int   n_err;
  logic len_err_exp;

  axi_read_dma_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE_WIDTH(24)) bus ();

  axi_read_dma_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE_WIDTH(24), .MAX_BURST_LEN(256)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus),
    .busy(busy), .done(done), .len_error(len_error)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and play slave/consumer until it completes (or abort_at beats were forwarded).
  task automatic run_cmd(input logic [31:0] addr, input logic [23:0] size, input int ar_delay,
                         input int rdy_pct, input int bad_beat, input int abort_at);
    logic [31:0] qa[$];
    int          ql[$];
    logic [31:0] a;
    logic [31:0] cur_data;
    logic [31:0] held_addr;
    logic [7:0]  held_len;
    int rem, len, beats_left, beat_idx, blen, burst_no, ar_wait, beats_total;
    bit r_hold, ar_seen, done_due, done_next, finished, exp_last;

    a   = addr & 32'hFFFF_FFFC;
    rem = int'(size);
    while (rem > 0) begin
      len = (4096 - int'(a[11:0])) / 4;
      if (len > 256) len = 256;
      if (len > rem) len = rem;
      qa.push_back(a);
      ql.push_back(len);
      a   = a + 32'(len * 4);
      rem = rem - len;
    end

    @(negedge ACLK);
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_valid = 1'b1;
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_size  = 24'($urandom);

    beats_left = 0; beat_idx = 0; blen = 0; burst_no = 0; ar_wait = 0; beats_total = 0;
    r_hold = 0; ar_seen = 0; finished = 0; done_next = 0; cur_data = 32'd0;
    held_addr = 32'd0; held_len = 8'd0;
    done_due = (size == 24'd0);

    for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
      if (beats_left > 0) begin
        if (!r_hold) begin
          bus.rvalid = ($urandom_range(0, 3) != 0);
          cur_data   = $urandom;
          bus.rdata  = cur_data;
          bus.rlast  = (beat_idx == blen - 1) ^ (burst_no == 1 && beat_idx == bad_beat);
        end
      end else begin
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.arready   = bus.arvalid && (ar_wait >= ar_delay);
      #1;
      chk("busy", 64'(busy), 64'(qa.size() > 0 || beats_left > 0));
      chk("done", 64'(done), 64'(done_due));
      chk("len_error", 64'(len_error), 64'(len_err_exp));
      chk("arvalid", 64'(bus.arvalid), 64'(beats_left == 0 && qa.size() > 0));
      chk("rready", 64'(bus.rready), 64'(beats_left > 0 && bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(bus.rvalid));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(qa.size() == 0 && beats_left == 0));

      if (bus.arvalid && qa.size() > 0) begin
        if (!ar_seen) begin
          chk("araddr", 64'(bus.araddr), 64'(qa[0]));
          chk("arlen", 64'(bus.arlen), 64'(ql[0] - 1));
          held_addr = bus.araddr;
          held_len  = bus.arlen;
          ar_seen   = 1;
        end else begin
          chk("araddr_stable", 64'(bus.araddr), 64'(held_addr));
          chk("arlen_stable", 64'(bus.arlen), 64'(held_len));
        end
        if (bus.arready) begin
          blen       = ql.pop_front();
          void'(qa.pop_front());
          beats_left = blen;
          beat_idx   = 0;
          burst_no++;
          ar_seen    = 0;
          ar_wait    = 0;
        end else begin
          ar_wait++;
        end
      end

      if (bus.rvalid && bus.rready) begin
        chk("out_data", 64'(bus.out_data), 64'(cur_data));
        exp_last = (beat_idx == blen - 1);
        if (bus.rlast != exp_last) len_err_exp = 1'b1;
        beats_total++;
        beats_left--;
        beat_idx++;
        r_hold = 0;
        if (beats_left == 0 && qa.size() == 0) done_next = 1;
      end else begin
        r_hold = bus.rvalid;
      end

      if (done_due) begin
        finished = 1;
      end else begin
        done_due  = done_next;
        done_next = 0;
      end
      if (abort_at >= 0 && beats_total >= abort_at) finished = 1;
      if (!finished) @(negedge ACLK);
    end

    if (!finished) chk("cycle_budget", 64'd0, 64'd1);
    if (abort_at < 0) begin
      chk("beat_total", 64'(beats_total), 64'(size));
      chk("bursts_left", 64'(qa.size()), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    n_vec = 0;
    n_err = 0;
    len_err_exp = 1'b0;
    ARESET = 1'b1;
    bus.cmd_addr = 32'd0; bus.cmd_size = 24'd0; bus.cmd_valid = 1'b0;
    bus.arready = 1'b0; bus.rdata = 32'd0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_len_error", 64'(len_error), 64'd0);
    chk("rst_rready", 64'(bus.rready), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    run_cmd(32'h0000_0100, 24'd4, 0, 100, -1, -1);
    run_cmd(32'h0000_0000, 24'd300, 0, 100, -1, -1);
    run_cmd(32'h0000_0FF8, 24'd4, 0, 100, -1, -1);
    run_cmd(32'h0000_0040, 24'd0, 0, 100, -1, -1);
    run_cmd(32'h0000_2FFE, 24'd5, 3, 50, -1, -1);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'(4096 - 4 * $urandom_range(1, 300)) | 12'($urandom_range(0, 3));
      run_cmd(ra, 24'($urandom_range(1, 600)), 3, 50, -1, -1);
    end
    run_cmd(32'hFFFF_FFF0, 24'd8, 1, 70, -1, -1);

    run_cmd(32'h0000_0200, 24'd4, 0, 100, 1, -1);
    chk("len_error_sticky", 64'(len_error), 64'd1);

    run_cmd(32'h0000_0300, 24'd8, 0, 100, -1, 2);
    ARESET = 1'b1;
    bus.rvalid = 1'b0;
    bus.arready = 1'b0;
    @(negedge ACLK);
    len_err_exp = 1'b0;
    chk("midrst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd0);
    chk("midrst_rready", 64'(bus.rready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_len_error", 64'(len_error), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    run_cmd(32'h0000_0500, 24'd3, 2, 60, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
